div_unit: RTL and testbench
===========================

// Module: div_unit
// PURPOSE
//   Multicycle 32-bit integer divider for the MIPS datapath (DIV, and DIVU when enabled).
//   Produces LO = quotient and HI = remainder. Both are registered outputs and feed the
//   HI/LO inputs of the write-back select mux.
//   The control FSM starts an operation with a one-cycle start pulse and stalls until done.
//   A zero divisor raises div_zero instead of computing.
// PARAMETERS
//   WIDTH  32  operand/result width; state counter is $clog2(WIDTH)+1 bits
// PORTS
//   clk        in   1      single clock, all state on rising edge
//   reset_n    in   1      asynchronous, active-low reset
//   start      in   1      request; sampled only in IDLE
//   dividend   in   WIDTH  A operand (rs), sampled with start
//   divisor    in   WIDTH  B operand (rt), sampled with start
//   divu       in   1      only with DIV_UNSIGNED_EN: 1 = unsigned divide
//   busy       out  1      high in PREP/RUN/FIX
//   done       out  1      one-cycle pulse, result or div_zero valid
//   div_zero   out  1      one-cycle pulse with done when divisor == 0
//   hi         out  WIDTH  remainder, held until the next successful op
//   lo         out  WIDTH  quotient, held until the next successful op
// BEHAVIOUR
//   Reset (async, any state): state=IDLE; busy=done=div_zero=0; hi=lo=0; counter=0.
//   FSM states: IDLE, PREP, RUN, FIX, DONE.
//     IDLE -> PREP  on start with divisor != 0.
//     IDLE -> DONE  on start with divisor == 0; div_zero=1 at T+1; hi/lo unchanged.
//     PREP: latch |dividend| and |divisor| (raw values if unsigned) and both signs;
//           clear the remainder accumulator; counter = WIDTH.
//     RUN: one restoring step per cycle: shift {rem,quo} left 1, trial-subtract divisor,
//          set quotient bit on a non-negative result. Decrement counter; leave RUN at 0.
//     FIX: signed only: negate quotient if signs differ; give remainder the dividend's
//          sign; load hi/lo.
//     DONE: done=1 for exactly one cycle, then IDLE.
//   Latency: start high in cycle T -> done high in cycle T+WIDTH+3 (T+35 at 32).
//   start while busy or in DONE is ignored; no queueing.
//   Operands are captured at T; later input changes do not affect the result.
//   Rounding: truncation toward zero. 0x80000000 / -1 -> lo=0x80000000, hi=0, no flag.
//   Reset mid-operation: abort. hi/lo go to 0, with no done pulse.
// CONFIGURATION
//   DIV_UNSIGNED_EN defined: divu port exists, is sampled with start, and selects DIVU
//     (no abs/sign fix).
//   DIV_UNSIGNED_EN undefined: no divu port; every operation is signed DIV.
// STRUCTURE
//   Shared header cpu_defs.vh:
//     - FSM state localparams (DIV_IDLE..DIV_DONE, 3 bits)
//     - the WIDTH default
//   Sub-module div_step: combinational single restoring step.
//     in:  rem, quo, divisor
//     out: next rem, next quo
//     Instantiated once and used each RUN cycle.
// TESTING
//   1. 100 / 7 -> lo=14, hi=2, done at T+35, busy high for T+1..T+34.
//   2. -100 / 7 -> lo=0xFFFFFFF2 (-14), hi=0xFFFFFFFE (-2).
//      100 / -7 -> lo=-14, hi=2.
//   3. 5 / 0 -> done and div_zero high at T+1; hi/lo keep the previous values (2/14).
//   4. 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
//   5. start pulsed again at T+10 and T+35 -> ignored; result and single done pulse
//      as for the first request.
//   6. reset_n low at T+20 -> busy=done=0 and hi=lo=0 at once.
//      With DIV_UNSIGNED_EN: divu=1, 0xFFFFFFFE / 2 -> lo=0x7FFFFFFF, hi=0.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the multicycle divider: default width and FSM state encoding.
package div_pkg;

  localparam int unsigned DivWidth = 32;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StPrep = 3'd1,
    StRun  = 3'd2,
    StFix  = 3'd3,
    StDone = 3'd4
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {rem,quo} left, trial-subtract divisor, set quotient bit.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    // Extra top bit keeps the shifted remainder exact for unsigned divisors above 2^(W-1).
    shifted = {rem_i, quo_i[WIDTH-1]};
    diff    = shifted - {1'b0, divisor_i};
    if (!diff[WIDTH]) begin
      rem_o = diff[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = shifted[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multicycle 32-bit divider (LO = quotient, HI = remainder). Define DIV_UNSIGNED_EN to add
// the divu_i port selecting DIVU; otherwise every operation is signed DIV.
module div_unit
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DivWidth
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
`ifdef DIV_UNSIGNED_EN
  input  logic             divu_i,
`endif
  output logic             busy_o,
  output logic             done_o,
  output logic             div_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  div_state_e      state_q;
  logic [WIDTH-1:0] a_q, b_q, rem_q, quo_q, hi_q, lo_q;
  logic [WIDTH-1:0] rem_step, quo_step;
  logic [CntW-1:0]  cnt_q;
  logic             uns_q, qneg_q, rneg_q;
  logic             busy_q, done_q, zero_q;
  logic             divu;

`ifdef DIV_UNSIGNED_EN
  assign divu = divu_i;
`else
  assign divu = 1'b0;
`endif

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_i    (rem_q),
    .quo_i    (quo_q),
    .divisor_i(b_q),
    .rem_o    (rem_step),
    .quo_o    (quo_step)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      uns_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            a_q   <= dividend_i;
            b_q   <= divisor_i;
            uns_q <= divu;
            if (divisor_i == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
              zero_q  <= 1'b1;
            end else begin
              state_q <= StPrep;
              busy_q  <= 1'b1;
            end
          end
        end
        StPrep: begin
          quo_q   <= (!uns_q && a_q[WIDTH-1]) ? -a_q : a_q;
          b_q     <= (!uns_q && b_q[WIDTH-1]) ? -b_q : b_q;
          qneg_q  <= !uns_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          rneg_q  <= !uns_q && a_q[WIDTH-1];
          rem_q   <= '0;
          cnt_q   <= CntW'(WIDTH);
          state_q <= StRun;
        end
        StRun: begin
          rem_q <= rem_step;
          quo_q <= quo_step;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CntW'(1)) state_q <= StFix;
        end
        StFix: begin
          lo_q    <= qneg_q ? -quo_q : quo_q;
          hi_q    <= rneg_q ? -rem_q : rem_q;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= StDone;
        end
        StDone: begin
          done_q  <= 1'b0;
          zero_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign div_zero_o = zero_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed, table-driven bench for div_unit plus hand sequences for restart and reset abort.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] dividend, divisor;
  logic        divu;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_unit #(
    .WIDTH(32)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .start_i   (start),
    .dividend_i(dividend),
    .divisor_i (divisor),
`ifdef DIV_UNSIGNED_EN
    .divu_i    (divu),
`endif
    .busy_o    (busy),
    .done_o    (done),
    .div_zero_o(div_zero),
    .hi_o      (hi),
    .lo_o      (lo)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        u;
    logic [31:0] exp_lo;
    logic [31:0] exp_hi;
    logic        exp_zero;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one cycle, then wait for done; report latency and busy-cycle count.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic u,
                        output int lat, output int busy_cnt);
    dividend = a;
    divisor  = b;
    divu     = u;
    start    = 1'b1;
    step();
    start    = 1'b0;
    dividend = 32'hDEAD_BEEF;
    divisor  = 32'h0000_0000;
    divu     = 1'b0;
    lat      = 1;
    busy_cnt = 0;
    while (!done && lat < 60) begin
      if (busy) busy_cnt++;
      step();
      lat++;
    end
    if (!done) begin
      errors++;
      $display("FAIL timeout: no done within %0d cycles", lat);
    end
  endtask

  vec_t vecs[$];

  initial begin
    int lat, bc, done_cnt, done_at, busy_after;

    vecs.push_back('{32'd100,       32'd7,         1'b0, 32'd14,        32'd2,         1'b0});
    vecs.push_back('{32'd5,         32'd0,         1'b0, 32'd14,        32'd2,         1'b1});
    vecs.push_back('{-32'sd100,     32'd7,         1'b0, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0});
    vecs.push_back('{32'd100,       -32'sd7,       1'b0, 32'hFFFF_FFF2, 32'd2,         1'b0});
    vecs.push_back('{-32'sd100,     -32'sd7,       1'b0, 32'd14,        32'hFFFF_FFFE, 1'b0});
    vecs.push_back('{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 32'd0,         1'b0});
    vecs.push_back('{32'd7,         32'd100,       1'b0, 32'd0,         32'd7,         1'b0});
    vecs.push_back('{32'd0,         32'd5,         1'b0, 32'd0,         32'd0,         1'b0});
    vecs.push_back('{32'h7FFF_FFFF, 32'd1,         1'b0, 32'h7FFF_FFFF, 32'd0,         1'b0});
    vecs.push_back('{32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 32'd0,         32'hFFFF_FFFF, 1'b0});
    vecs.push_back('{32'h8000_0000, 32'h8000_0000, 1'b0, 32'd1,         32'd0,         1'b0});
`ifdef DIV_UNSIGNED_EN
    vecs.push_back('{32'hFFFF_FFFE, 32'd2,         1'b1, 32'h7FFF_FFFF, 32'd0,         1'b0});
    vecs.push_back('{32'hFFFF_FFFF, 32'd10,        1'b1, 32'h1999_9999, 32'd5,         1'b0});
`endif

    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0; divu = 1'b0;
    #12;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset div_zero", {31'd0, div_zero}, 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    rst_n = 1'b1;
    step();

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].u, lat, bc);
      check($sformatf("v%0d latency", i), lat, vecs[i].exp_zero ? 32'd1 : 32'd35);
      check($sformatf("v%0d busy cycles", i), bc, vecs[i].exp_zero ? 32'd0 : 32'd34);
      check($sformatf("v%0d busy at done", i), {31'd0, busy}, 32'd0);
      check($sformatf("v%0d lo", i), lo, vecs[i].exp_lo);
      check($sformatf("v%0d hi", i), hi, vecs[i].exp_hi);
      check($sformatf("v%0d div_zero", i), {31'd0, div_zero}, {31'd0, vecs[i].exp_zero});
      step();
      check($sformatf("v%0d done pulse width", i), {31'd0, done}, 32'd0);
    end

    // Extra start pulses at T+10 and T+35 plus changed operands must not disturb 1000/3.
    dividend = 32'd1000; divisor = 32'd3; divu = 1'b0; start = 1'b1;
    step();
    dividend = 32'd7; divisor = 32'd0;
    done_cnt = 0; done_at = 0; busy_after = 0;
    for (int k = 1; k <= 45; k++) begin
      start = (k == 10 || k == 35);
      if (done) begin
        done_cnt++;
        if (done_at == 0) done_at = k;
      end
      if (k == 36) busy_after = int'(busy);
      step();
    end
    start = 1'b0;
    check("restart done count", done_cnt, 32'd1);
    check("restart done cycle", done_at, 32'd35);
    check("restart busy T+36", busy_after, 32'd0);
    check("restart lo", lo, 32'd333);
    check("restart hi", hi, 32'd1);

    // Asynchronous reset at T+20 aborts the operation and clears hi/lo at once.
    dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k < 20; k++) step();
    check("pre-abort busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    check("abort hi", hi, 32'd0);
    check("abort lo", lo, 32'd0);
    step();
    rst_n = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) done_cnt++;
      step();
    end
    check("abort no done", done_cnt, 32'd0);

    run_op(32'd100, 32'd7, 1'b0, lat, bc);
    check("post-abort latency", lat, 32'd35);
    check("post-abort lo", lo, 32'd14);
    check("post-abort hi", hi, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
